// File: rtl/mod_instr_fetch_ctrl.sv
// Instruction fetch controller: walks a word-addressed ROM into a small fetch queue for decode,
// with branch/jump redirect, end-of-program drain and a saturating delivered-instruction count.
module mod_instr_fetch_ctrl #(
  parameter logic [29:0] RESET_PC = 30'd0,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [29:0] rom_address,
  input  logic [31:0] rom_instruction,
  input  logic        rom_mem_end,
  input  logic        redirect_valid,
  input  logic [29:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [29:0] out_pc,
  output logic        halted,
  output logic [15:0] instr_count
);

  localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FQ_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t           state;
  logic [29:0]      fetch_pc;
  logic [29:0]      q_pc    [FQ_DEPTH];
  logic [31:0]      q_instr [FQ_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [15:0]      delivered;

  logic q_empty;
  logic q_full;
  logic pop;
  logic push;
  logic redirect_take;

  // Queue handshakes; a redirect outside IDLE flushes and blocks this cycle's push.
  always_comb begin
    q_empty       = (count == CNT_ZERO);
    q_full        = (count == FULL_CNT);
    pop           = 1'b0;
    push          = 1'b0;
    redirect_take = 1'b0;
    if (redirect_valid && (state != IDLE)) begin
      redirect_take = 1'b1;
    end else begin
      redirect_take = 1'b0;
    end
    if (!q_empty && out_ready) begin
      pop = 1'b1;
    end else begin
      pop = 1'b0;
    end
    if ((state == FETCH) && !rom_mem_end && !redirect_valid && (!q_full || pop)) begin
      push = 1'b1;
    end else begin
      push = 1'b0;
    end
  end

  // Control FSM, fetch PC, queue pointers/occupancy and delivered count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      rd_ptr    <= PTR_ZERO;
      wr_ptr    <= PTR_ZERO;
      count     <= CNT_ZERO;
      delivered <= 16'd0;
    end else begin
      if (pop && (delivered != 16'hFFFF)) begin
        delivered <= delivered + 16'd1;
      end
      if (redirect_take) begin
        rd_ptr <= PTR_ZERO;
        wr_ptr <= PTR_ZERO;
        count  <= CNT_ZERO;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
      if (push) begin
        fetch_pc <= fetch_pc + 30'd1;
      end
      // Redirect outranks start and end-of-memory; start only acts from IDLE/HALT.
      if (redirect_take) begin
        state    <= FETCH;
        fetch_pc <= redirect_target;
      end else begin
        case (state)
          IDLE, HALT: begin
            if (start) begin
              state     <= FETCH;
              fetch_pc  <= RESET_PC;
              delivered <= 16'd0;
            end
          end
          FETCH: begin
            if (rom_mem_end) begin
              state <= DRAIN;
            end
          end
          DRAIN: begin
            if (q_empty) begin
              state <= HALT;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Queue storage; cleared on reset so no stale entry can ever surface.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        q_pc[i]    <= 30'd0;
        q_instr[i] <= 32'd0;
      end
    end else if (push) begin
      q_pc[wr_ptr]    <= fetch_pc;
      q_instr[wr_ptr] <= rom_instruction;
    end
  end

  assign rom_address     = fetch_pc;
  assign out_valid       = !q_empty;
  assign out_pc          = q_empty ? 30'd0 : q_pc[rd_ptr];
  assign out_instruction = q_empty ? 32'd0 : q_instr[rd_ptr];
  assign halted          = (state == HALT);
  assign instr_count     = delivered;

endmodule

// File: tb/tb_mod_instr_fetch_ctrl.sv
// Directed bench for mod_instr_fetch_ctrl: per-cycle vector table plus hand-written
// sequences for full-program run, halt/redirect, start+redirect and mid-fetch reset.
module tb_mod_instr_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [29:0] rom_address;
  logic [31:0] rom_instruction;
  logic        rom_mem_end;
  logic        redirect_valid;
  logic [29:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [29:0] out_pc;
  logic        halted;
  logic [15:0] instr_count;

  int checks;
  int failures;

  mod_instr_fetch_ctrl #(.RESET_PC(30'd0), .FQ_DEPTH(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .rom_address     (rom_address),
    .rom_instruction (rom_instruction),
    .rom_mem_end     (rom_mem_end),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .halted          (halted),
    .instr_count     (instr_count)
  );

  function automatic logic [31:0] rom_word(input logic [29:0] a);
    return {a, 2'b01} ^ 32'h5A5A_0F0F;
  endfunction

  // Program occupies words 0..43.
  assign rom_instruction = rom_word(rom_address);
  assign rom_mem_end     = (rom_address > 30'd43);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        ready;
    logic        redir;
    logic [29:0] target;
    logic        exp_valid;
    logic [29:0] exp_pc;
    logic [29:0] exp_addr;
    logic        exp_halted;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tab [19];

  function automatic vec_t mk(input logic s, input logic r, input logic d, input logic [29:0] t,
                              input logic v, input logic [29:0] p, input logic [29:0] a,
                              input logic h, input logic [15:0] c);
    vec_t x;
    x.start = s; x.ready = r; x.redir = d; x.target = t;
    x.exp_valid = v; x.exp_pc = p; x.exp_addr = a; x.exp_halted = h; x.exp_cnt = c;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_target = 30'd0; out_ready = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic wait_halted(input int max_cycles);
    int n;
    n = 0;
    @(negedge clk);
    while (!halted && (n < max_cycles)) begin
      next_cycle();
      @(negedge clk);
      n++;
    end
    chk("halt_wait", 64'(halted), 64'(1'b1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_target = 30'd0; out_ready = 1'b0;

    // Vector table: start latency, back-pressure, start ignored in FETCH, redirect with pop.
    tab[0]  = mk(1'b1, 1'b0, 1'b0, 30'd0, 1'b0, 30'd0, 30'd0, 1'b0, 16'd0);
    tab[1]  = mk(1'b0, 1'b0, 1'b0, 30'd0, 1'b0, 30'd0, 30'd0, 1'b0, 16'd0);
    tab[2]  = mk(1'b0, 1'b0, 1'b0, 30'd0, 1'b1, 30'd0, 30'd1, 1'b0, 16'd0);
    tab[3]  = mk(1'b0, 1'b0, 1'b0, 30'd0, 1'b1, 30'd0, 30'd2, 1'b0, 16'd0);
    tab[4]  = mk(1'b0, 1'b0, 1'b0, 30'd0, 1'b1, 30'd0, 30'd2, 1'b0, 16'd0);
    tab[5]  = mk(1'b0, 1'b0, 1'b0, 30'd0, 1'b1, 30'd0, 30'd2, 1'b0, 16'd0);
    tab[6]  = mk(1'b0, 1'b1, 1'b0, 30'd0, 1'b1, 30'd0, 30'd2, 1'b0, 16'd0);
    tab[7]  = mk(1'b0, 1'b1, 1'b0, 30'd0, 1'b1, 30'd1, 30'd3, 1'b0, 16'd1);
    tab[8]  = mk(1'b1, 1'b1, 1'b0, 30'd0, 1'b1, 30'd2, 30'd4, 1'b0, 16'd2);
    tab[9]  = mk(1'b0, 1'b1, 1'b0, 30'd0, 1'b1, 30'd3, 30'd5, 1'b0, 16'd3);
    for (int k = 10; k <= 14; k++) begin
      tab[k] = mk(1'b0, 1'b1, 1'b0, 30'd0, 1'b1, 30'(k - 6), 30'(k - 4), 1'b0, 16'(k - 6));
    end
    tab[15] = mk(1'b0, 1'b1, 1'b1, 30'd5, 1'b1, 30'd9, 30'd11, 1'b0, 16'd9);
    tab[16] = mk(1'b0, 1'b1, 1'b0, 30'd0, 1'b0, 30'd0, 30'd5, 1'b0, 16'd10);
    tab[17] = mk(1'b0, 1'b1, 1'b0, 30'd0, 1'b1, 30'd5, 30'd6, 1'b0, 16'd10);
    tab[18] = mk(1'b0, 1'b1, 1'b0, 30'd0, 1'b1, 30'd6, 30'd7, 1'b0, 16'd11);

    // Reset wins over start and redirect.
    rst = 1'b1; start = 1'b1; redirect_valid = 1'b1; redirect_target = 30'd9;
    next_cycle();
    rst = 1'b0; start = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_addr", 64'(rom_address), 64'(30'd0));
    chk("rst_pc", 64'(out_pc), 64'(30'd0));
    chk("rst_instr", 64'(out_instruction), 64'(32'd0));
    chk("rst_halted", 64'(halted), 64'(1'b0));
    chk("rst_count", 64'(instr_count), 64'(16'd0));

    // Redirect in IDLE is ignored.
    next_cycle();
    redirect_valid = 1'b1; redirect_target = 30'd9;
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("idle_redir_addr", 64'(rom_address), 64'(30'd0));
    next_cycle();
    @(negedge clk);
    chk("idle_redir_valid", 64'(out_valid), 64'(1'b0));
    next_cycle();

    for (int i = 0; i < 19; i++) begin
      start = tab[i].start; out_ready = tab[i].ready;
      redirect_valid = tab[i].redir; redirect_target = tab[i].target;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(tab[i].exp_valid));
      chk($sformatf("vec%0d_pc", i), 64'(out_pc), 64'(tab[i].exp_pc));
      chk($sformatf("vec%0d_addr", i), 64'(rom_address), 64'(tab[i].exp_addr));
      chk($sformatf("vec%0d_halted", i), 64'(halted), 64'(tab[i].exp_halted));
      chk($sformatf("vec%0d_cnt", i), 64'(instr_count), 64'(tab[i].exp_cnt));
      chk($sformatf("vec%0d_instr", i), 64'(out_instruction),
          64'(tab[i].exp_valid ? rom_word(tab[i].exp_pc) : 32'd0));
      next_cycle();
    end
    start = 1'b0; redirect_valid = 1'b0;

    // Full program with out_ready held high.
    do_reset();
    start = 1'b1; out_ready = 1'b1;
    next_cycle();
    start = 1'b0;
    @(negedge clk);
    chk("run_n1_valid", 64'(out_valid), 64'(1'b0));
    next_cycle();
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      chk($sformatf("run_valid%0d", i), 64'(out_valid), 64'(1'b1));
      chk($sformatf("run_pc%0d", i), 64'(out_pc), 64'(30'(i)));
      chk($sformatf("run_instr%0d", i), 64'(out_instruction), 64'(rom_word(30'(i))));
      next_cycle();
    end
    @(negedge clk);
    chk("run_drain_valid", 64'(out_valid), 64'(1'b0));
    chk("run_drain_halted", 64'(halted), 64'(1'b0));
    next_cycle();
    @(negedge clk);
    chk("run_halted", 64'(halted), 64'(1'b1));
    chk("run_count", 64'(instr_count), 64'(16'd44));

    // Redirect to 0 out of HALT refetches the program; the count keeps accumulating.
    next_cycle();
    redirect_valid = 1'b1; redirect_target = 30'd0;
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("halt_redir_halted", 64'(halted), 64'(1'b0));
    chk("halt_redir_addr", 64'(rom_address), 64'(30'd0));
    chk("halt_redir_valid", 64'(out_valid), 64'(1'b0));
    next_cycle();
    @(negedge clk);
    chk("halt_redir_pc0_valid", 64'(out_valid), 64'(1'b1));
    chk("halt_redir_pc0", 64'(out_pc), 64'(30'd0));
    next_cycle();
    wait_halted(200);
    chk("halt_redir_count", 64'(instr_count), 64'(16'd88));

    // Start together with redirect in HALT: the redirect target wins.
    next_cycle();
    start = 1'b1; redirect_valid = 1'b1; redirect_target = 30'd7;
    next_cycle();
    start = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    chk("sr_halted", 64'(halted), 64'(1'b0));
    chk("sr_addr", 64'(rom_address), 64'(30'd7));
    next_cycle();
    @(negedge clk);
    chk("sr_valid", 64'(out_valid), 64'(1'b1));
    chk("sr_pc7", 64'(out_pc), 64'(30'd7));
    next_cycle();
    @(negedge clk);
    chk("sr_pc8", 64'(out_pc), 64'(30'd8));

    // Fill the queue with fetch_pc at 20, then reset mid-fetch.
    begin
      int n;
      n = 0;
      while ((rom_address != 30'd19) && (n < 100)) begin
        next_cycle();
        @(negedge clk);
        n++;
      end
      chk("reach_pc19", 64'(rom_address), 64'(30'd19));
    end
    out_ready = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("full_addr", 64'(rom_address), 64'(30'd20));
    chk("full_pc", 64'(out_pc), 64'(30'd18));
    next_cycle();
    @(negedge clk);
    chk("full_stall_addr", 64'(rom_address), 64'(30'd20));
    chk("full_stall_pc", 64'(out_pc), 64'(30'd18));
    rst = 1'b1; start = 1'b1; redirect_valid = 1'b1; redirect_target = 30'd3;
    next_cycle();
    rst = 1'b0; start = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 64'(out_valid), 64'(1'b0));
    chk("midrst_addr", 64'(rom_address), 64'(30'd0));
    chk("midrst_count", 64'(instr_count), 64'(16'd0));
    chk("midrst_halted", 64'(halted), 64'(1'b0));
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("midrst_idle%0d", i), 64'(out_valid), 64'(1'b0));
    end
    next_cycle();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    @(negedge clk);
    chk("resume_n1_valid", 64'(out_valid), 64'(1'b0));
    next_cycle();
    @(negedge clk);
    chk("resume_valid", 64'(out_valid), 64'(1'b1));
    chk("resume_pc", 64'(out_pc), 64'(30'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
